// File: rtl/keypad_scanner_4x4_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Contents: key_code_t, kp_state_t, kp_res_t (pressed flag + code), KP_COLS/KP_ROWS,
//           kp_encode (row bits + column -> code), kp_pick (higher code wins).
package keypad_pkg;

   localparam int KP_COLS = 4;
   localparam int KP_ROWS = 4;

   typedef logic [3:0] key_code_t;

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} kp_state_t;

   // code is kept at zero whenever pressed is clear, so whole-struct compares are exact
   typedef struct packed {
      logic      pressed;
      key_code_t code;
   } kp_res_t;

   localparam kp_res_t KP_NONE = '0;

   // Rows are active-low. Scanning upward lets the highest pressed row overwrite lower ones.
   function automatic kp_res_t kp_encode(input logic [KP_ROWS-1:0] rows_n, input logic [1:0] col);
      kp_res_t r;
      r = KP_NONE;
      for (int i = 0; i < KP_ROWS; i++) begin
         if (!rows_n[i]) begin
            r.pressed = 1'b1;
            r.code    = {i[1:0], col};
         end
      end
      return r;
   endfunction

   function automatic kp_res_t kp_pick(input kp_res_t a, input kp_res_t b);
      if (b.pressed && (!a.pressed || (b.code > a.code))) return b;
      return a;
   endfunction

endpackage

// File: rtl/keypad_scanner_4x4_if.sv
// keypad_scanner_4x4_if: key event valid/ready channel from scanner to consumer.
// Latency: none (wires only).
// Backpressure: the consumer holds key_ready low to stall; the producer keeps key_code stable meanwhile.
// Signals: key_valid (event pending), key_code (row*4+col), key_ready (consumer accepts).
interface keypad_scanner_4x4_if;
   import keypad_pkg::*;

   logic      key_valid;
   key_code_t key_code;
   logic      key_ready;

   modport master (output key_valid, output key_code, input key_ready);
   modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/keypad_scanner_4x4_debounce.sv
// keypad_debounce: accepts a new stable sweep result after DEBOUNCE_SCANS identical sweeps.
// Latency: stable_o / change_o / sweep_o update one cycle after the accepting sweep_done_i.
// Backpressure: none; consumes one result per sweep_done_i strobe.
// Ports: clk_i, rst_i (sync, active-high), sweep_done_i, res_i (sweep result),
//        stable_o (debounced result), change_o (1-cycle, stable_o just changed),
//        sweep_o (sweep_done_i delayed to line up with change_o).
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  logic    sweep_done_i,
   input  kp_res_t res_i,
   output kp_res_t stable_o,
   output logic    change_o,
   output logic    sweep_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

   kp_res_t          prev_q, stable_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             change_q, sweep_q;

   // Run length of the current result, saturating so a long hold cannot wrap.
   always_comb begin
      cnt_d = cnt_q;
      if (res_i != prev_q)      cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q   <= KP_NONE;
         stable_q <= KP_NONE;
         cnt_q    <= '0;
         change_q <= 1'b0;
         sweep_q  <= 1'b0;
      end else begin
         change_q <= 1'b0;
         sweep_q  <= sweep_done_i;
         if (sweep_done_i) begin
            prev_q <= res_i;
            cnt_q  <= cnt_d;
            if ((cnt_d == CNT_MAX) && (res_i != stable_q)) begin
               stable_q <= res_i;
               change_q <= 1'b1;
            end
         end
      end
   end

   assign stable_o = stable_q;
   assign change_o = change_q;
   assign sweep_o  = sweep_q;

endmodule

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: scans a 4x4 hex key matrix and emits one code per debounced press.
// Latency: press to key_valid is DEBOUNCE_SCANS..DEBOUNCE_SCANS+1 sweeps plus a few cycles.
// Backpressure: one-entry output register; a new event while it is full and not drained is dropped with an overflow pulse.
// Ports: clk_i, rst_i (sync, active-high), col_n_o (one column low), row_n_i (raw rows, async),
//        key_down_o (debounced key held), overflow_o (1-cycle drop pulse), kp_if (master: key_valid/key_code/key_ready).
// Config: define KEYPAD_SCANNER_REPEAT_EN to add auto-repeat (REPEAT_DELAY then every REPEAT_RATE sweeps).
module keypad_scanner_4x4
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 16,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 32,
   parameter int REPEAT_RATE    = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   output logic [KP_COLS-1:0]  col_n_o,
   input  logic [KP_ROWS-1:0]  row_n_i,
   output logic                key_down_o,
   output logic                overflow_o,
   keypad_scanner_4x4_if.master kp_if
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [KP_ROWS-1:0] sync1_q, sync2_q;
   logic [DIV_W-1:0]   div_cnt_q;
   logic [1:0]         col_idx_q;
   logic [KP_COLS-1:0] col_n_q;
   kp_res_t            acc_q, res_q, samp, merged;
   logic               sweep_done_q;

   kp_res_t            stb;
   logic               stb_chg, sweep_tick;

   kp_state_t          state_q;
   logic               key_valid_q, overflow_q, ev_vld;
   key_code_t          key_code_q;

   // ---------------- row synchroniser and column sequencing ----------------
   always_comb begin
      samp   = kp_encode(sync2_q, col_idx_q);
      merged = kp_pick(acc_q, samp);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q      <= '1;
         sync2_q      <= '1;
         div_cnt_q    <= '0;
         col_idx_q    <= '0;
         col_n_q      <= 4'b1110;
         acc_q        <= KP_NONE;
         res_q        <= KP_NONE;
         sweep_done_q <= 1'b0;
      end else begin
         sync1_q      <= row_n_i;
         sync2_q      <= sync1_q;
         sweep_done_q <= 1'b0;
         if (div_cnt_q == DIV_LAST) begin
            // last cycle of the slot: rows have settled through the synchroniser
            div_cnt_q <= '0;
            col_idx_q <= col_idx_q + 2'd1;
            col_n_q   <= {col_n_q[KP_COLS-2:0], col_n_q[KP_COLS-1]};
            if (col_idx_q == 2'd3) begin
               res_q        <= merged;
               sweep_done_q <= 1'b1;
               acc_q        <= KP_NONE;
            end else begin
               acc_q <= merged;
            end
         end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
         end
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .sweep_done_i (sweep_done_q),
      .res_i        (res_q),
      .stable_o     (stb),
      .change_o     (stb_chg),
      .sweep_o      (sweep_tick)
   );

   // ---------------- event FSM and output register ----------------
`ifdef KEYPAD_SCANNER_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_phase_q, rpt_phase_d;   // 0: waiting for first repeat, 1: repeating
`endif

   // A stable change to a pressed key is always a new key (IDLE->HELD or K->J).
   always_comb begin
      ev_vld = 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
      rpt_cnt_d   = rpt_cnt_q;
      rpt_phase_d = rpt_phase_q;
`endif
      case (state_q)
         IDLE: begin
            ev_vld = stb_chg && stb.pressed;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
`endif
         end
         HELD: begin
            ev_vld = stb_chg && stb.pressed;
`ifdef KEYPAD_SCANNER_REPEAT_EN
            if (stb_chg) begin
               rpt_cnt_d   = '0;
               rpt_phase_d = 1'b0;
            end else if (sweep_tick) begin
               rpt_cnt_d = rpt_cnt_q + 1'b1;
               if (rpt_cnt_d == (rpt_phase_q ? RPT_W'(REPEAT_RATE) : RPT_W'(REPEAT_DELAY))) begin
                  ev_vld      = 1'b1;
                  rpt_cnt_d   = '0;
                  rpt_phase_d = 1'b1;
               end
            end
`endif
         end
         default: ev_vld = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         key_valid_q <= 1'b0;
         key_code_q  <= '0;
         overflow_q  <= 1'b0;
`ifdef KEYPAD_SCANNER_REPEAT_EN
         rpt_cnt_q   <= '0;
         rpt_phase_q <= 1'b0;
`endif
      end else begin
         overflow_q <= 1'b0;
         if (stb_chg) state_q <= stb.pressed ? HELD : IDLE;
`ifdef KEYPAD_SCANNER_REPEAT_EN
         rpt_cnt_q   <= rpt_cnt_d;
         rpt_phase_q <= rpt_phase_d;
`endif
         if (ev_vld) begin
            // a same-cycle handshake frees the register for the new event
            if (!key_valid_q || kp_if.key_ready) begin
               key_valid_q <= 1'b1;
               key_code_q  <= stb.code;
            end else begin
               overflow_q <= 1'b1;
            end
         end else if (kp_if.key_ready) begin
            key_valid_q <= 1'b0;
         end
      end
   end

   assign col_n_o         = col_n_q;
   assign key_down_o      = stb.pressed;
   assign overflow_o      = overflow_q;
   assign kp_if.key_valid = key_valid_q;
   assign kp_if.key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: directed scenarios for the keypad scanner with a queue scoreboard.
// A behavioural key matrix pulls rows low for pressed keys in the driven column.
// A negedge monitor pops expected codes on every handshake and counts overflow pulses.
module tb_keypad_scanner_4x4;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  col_n;
   logic [3:0]  row_n;
   logic        key_down;
   logic        overflow;
   logic [15:0] keys;

   int          total = 0;
   int          bad   = 0;
   int          popped = 0;
   int          ovf_cnt = 0;
   int          cyc = 0;
   logic [3:0]  exp_q[$];
   int          pop_cyc[$];

   keypad_scanner_4x4_if kp_if();

   keypad_scanner_4x4 #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .REPEAT_DELAY   (32),
      .REPEAT_RATE    (8)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .col_n_o    (col_n),
      .row_n_i    (row_n),
      .key_down_o (key_down),
      .overflow_o (overflow),
      .kp_if      (kp_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // key matrix: pressed key at (r,c) connects column c to row r
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && kp_if.key_valid && kp_if.key_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event actual=%h required=none", kp_if.key_code);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (kp_if.key_code !== e) begin
               bad++;
               $display("FAIL event_code actual=%h required=%h", kp_if.key_code, e);
            end
         end
         pop_cyc.push_back(cyc);
         popped++;
      end
      if (!rst && overflow) ovf_cnt++;
   end

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // wait for the monitor to see a handshake; returns posedges waited
   task automatic wait_pop(input string name, input int bound, output int lat);
      int start;
      start = popped;
      lat = 0;
      while (popped == start && lat < bound) begin
         @(posedge clk);
         lat++;
      end
      if (popped == start) begin
         total++;
         bad++;
         $display("FAIL %s actual=timeout required=event within %0d cycles", name, bound);
      end
   endtask

   // sel 0: key_down, sel 1: key_valid
   task automatic wait_sig(input string name, input int sel, input logic val, input int bound);
      int   n;
      logic s;
      n = 0;
      forever begin
         @(negedge clk);
         s = (sel == 0) ? key_down : kp_if.key_valid;
         if (s == val) break;
         n++;
         if (n >= bound) begin
            total++;
            bad++;
            $display("FAIL %s actual=%0b required=%0b (timeout)", name, s, val);
            break;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p0, o0;
      keys = '0;
      rst = 1'b1;
      kp_if.key_ready = 1'b1;

      // ---- reset and column sequencing ----
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_col_n", col_n, 4'b1110);
      chk("rst_key_valid", kp_if.key_valid, 0);
      chk("rst_key_code", kp_if.key_code, 0);
      chk("rst_key_down", key_down, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("col0_held_3cyc", col_n, 4'b1110);
      @(posedge clk);
      @(negedge clk);
      chk("col1_after_4cyc", col_n, 4'b1101);
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("col3_at_15", col_n, 4'b0111);
      @(posedge clk);
      @(negedge clk);
      chk("wrap_at_16", col_n, 4'b1110);

      // ---- steady key 5 ----
      @(posedge clk); #1;
      keys[5] = 1'b1;
      exp_q.push_back(4'h5);
      wait_pop("press5", 100, lat);
      chk("lat5_in_range", int'(lat >= 32 && lat <= 68), 1);
      @(negedge clk);
      chk("valid_one_cycle", kp_if.key_valid, 0);
      chk("key5_down", key_down, 1);
      p0 = popped;
      repeat (160) @(posedge clk);
      chk("held5_no_more_events", popped - p0, 0);
      keys[5] = 1'b0;
      wait_sig("release5_down", 0, 1'b0, 100);

      // ---- glitching key 5: alternate every sweep ----
      p0 = popped;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         keys[5] = (i % 2 == 0);
         repeat (15) @(posedge clk);
      end
      repeat (64) @(posedge clk);
      chk("glitch_no_event", popped - p0, 0);
      chk("glitch_not_down", key_down, 0);
      @(posedge clk); #1;
      keys[5] = 1'b1;
      exp_q.push_back(4'h5);
      wait_pop("steady5_after_glitch", 100, lat);
      chk("lat5b_in_range", int'(lat >= 32 && lat <= 68), 1);
      keys[5] = 1'b0;
      wait_sig("release5b_down", 0, 1'b0, 100);

      // ---- keys 2 and E together, then E released, then 2 released ----
      @(posedge clk); #1;
      keys[2]  = 1'b1;
      keys[14] = 1'b1;
      exp_q.push_back(4'hE);
      wait_pop("press_2E", 100, lat);
      @(posedge clk); #1;
      keys[14] = 1'b0;
      exp_q.push_back(4'h2);
      wait_pop("release_E", 100, lat);
      p0 = popped;
      keys[2] = 1'b0;
      wait_sig("release2_down", 0, 1'b0, 100);
      repeat (32) @(posedge clk);
      chk("release_no_event", popped - p0, 0);

      // ---- backpressure: 3 held in register, 7 dropped ----
      @(posedge clk); #1;
      kp_if.key_ready = 1'b0;
      keys[3] = 1'b1;
      exp_q.push_back(4'h3);
      wait_sig("press3_valid", 1, 1'b1, 100);
      keys[3] = 1'b0;
      wait_sig("release3_down", 0, 1'b0, 100);
      o0 = ovf_cnt;
      keys[7] = 1'b1;
      wait_sig("press7_down", 0, 1'b1, 100);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("ovf_one_pulse", ovf_cnt - o0, 1);
      chk("ovf_valid_held", kp_if.key_valid, 1);
      chk("ovf_code_kept", kp_if.key_code, 3);
      repeat (32) @(posedge clk);
      chk("ovf_still_one", ovf_cnt - o0, 1);
      @(posedge clk); #1;
      kp_if.key_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("drain_valid_low", kp_if.key_valid, 0);
      keys[7] = 1'b0;
      wait_sig("release7_down", 0, 1'b0, 100);

      // ---- reset mid-operation discards the pending event ----
      @(posedge clk); #1;
      kp_if.key_ready = 1'b0;
      keys[1] = 1'b1;
      wait_sig("press1_valid", 1, 1'b1, 100);
      chk("pre_rst_down", key_down, 1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      keys[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_valid", kp_if.key_valid, 0);
      chk("midrst_col_n", col_n, 4'b1110);
      chk("midrst_down", key_down, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      kp_if.key_ready = 1'b1;

`ifdef KEYPAD_SCANNER_REPEAT_EN
      // ---- auto-repeat: press, +32 sweeps, +40 sweeps ----
      begin
         int c0;
         @(posedge clk); #1;
         keys[9] = 1'b1;
         repeat (3) exp_q.push_back(4'h9);
         c0 = pop_cyc.size();
         wait_pop("rpt_press", 100, lat);
         wait_pop("rpt_first", 600, lat);
         wait_pop("rpt_second", 200, lat);
         if (pop_cyc.size() == c0 + 3) begin
            chk("rpt_delay_cycles", pop_cyc[c0+1] - pop_cyc[c0], 32*16);
            chk("rpt_rate_cycles", pop_cyc[c0+2] - pop_cyc[c0+1], 8*16);
         end else begin
            chk("rpt_event_count", pop_cyc.size() - c0, 3);
         end
         keys[9] = 1'b0;
         wait_sig("release9_down", 0, 1'b0, 100);
      end
`endif

      repeat (4) @(posedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
- Sequencing controller for a 4x4 hex key matrix (keys 0-F).
- Drives the columns one at a time, samples the rows, debounces, and resolves multiple pressed keys with a fixed priority.
- Emits one 4-bit key code per debounced press event over a valid/ready handshake.
- Sits between the board keypad pins and the hex-entry datapath.

Parameters:
- SCAN_DIV, 16: clock cycles each column is driven; legal range >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full sweeps needed to accept a new stable state; legal range >= 1.
- REPEAT_DELAY, 32: sweeps a key must be held before the first auto-repeat (feature only).
- REPEAT_RATE, 8: sweeps between auto-repeat events (feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- col_n  out  4  column drive, active-low, exactly one bit low at any time.
- row_n  in  4  raw row inputs, active-low (pulled up); asynchronous to clk.
- key_valid  out  1  key_code holds an unconsumed event.
- key_code  out  4  key code = row*4 + col (0x0-0xF).
- key_ready  in  1  consumer accepts the event when key_valid & key_ready.
- key_down  out  1  a debounced key is currently held.
- overflow  out  1  one-cycle pulse: an event was dropped.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - col_n = 4'b1110; key_valid = 0; key_code = 0; key_down = 0; overflow = 0.
  - All counters = 0; debounce state = "none"; row synchroniser flops = 4'b1111.
  - A pending event is discarded when reset asserts mid-operation.
- row_n passes through a 2-flop synchroniser before use.
- Column sequencing:
  - Column c (0..3) is driven low for SCAN_DIV cycles. Order is 0,1,2,3, then wraps to 0.
  - Synchronised rows are sampled on the last cycle of each column slot.
  - One sweep = 4*SCAN_DIV cycles.
- Sweep result: pressed flag plus a code.
  - If several keys are low, the highest code wins (key F beats key 0).
  - No key low: result = "none".
- Debounce:
  - A saturating counter counts consecutive sweeps whose result equals the previous sweep's result. Any differing result resets the counter to 1.
  - When the count reaches DEBOUNCE_SCANS and the result differs from the stable state, the stable state is updated at the end of that sweep.
  - key_down = (stable state != none).
- Event generation FSM, states IDLE / HELD:
  - IDLE -> HELD on stable none -> key K: emit event K.
  - HELD -> HELD on stable K -> key J, with J != K: emit event J.
  - HELD -> IDLE on stable -> none: no event on release.
- Output register is one entry, loaded on the cycle after the sweep that emits the event.
  - key_valid holds until the handshake completes. key_code is stable while key_valid = 1.
  - New event, key_valid = 1, key_ready = 0: the new event is dropped, the register is unchanged, and overflow pulses for 1 cycle.
  - New event, key_valid = 1, key_ready = 1 in the same cycle: the old event is consumed and the new one loaded. key_valid stays 1; no overflow.
  - key_ready while key_valid = 0 is ignored.
- Latency, press to key_valid: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 sweeps, plus 3 cycles.

Optional Feature:
- Macro: KEYPAD_SCANNER_REPEAT_EN.
- Defined:
  - In HELD, a sweep counter runs while the stable key is unchanged.
  - First repeat event for the same key after REPEAT_DELAY sweeps, then every REPEAT_RATE sweeps.
  - A key change or release restarts the counter.
  - Repeat events use the same output register and the same overflow rules.
- Undefined: exactly one event per stable press; no repeat counter is synthesised; REPEAT_* parameters are unused.

Decomposition:
- Package keypad_pkg holds:
  - typedef key_code_t (logic [3:0]);
  - enum kp_state_t {IDLE, HELD};
  - constant KP_COLS = 4, KP_ROWS = 4;
  - function for the priority encoding of row bits plus column index to a code.
- Sub-module keypad_debounce: takes the sweep result plus a sweep_done strobe, and outputs the stable result plus a one-cycle change strobe.
- Column sequencing, the FSM, and the output register stay in the top module.

Test Plan:
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=3, and key_ready = 1 unless stated.
- Hold rst for 2 cycles, then release -> col_n = 1110; key_valid = 0; col_n advances to 1101 after 4 cycles; sweep wraps to 1110 at cycle 16.
- Press key 5 (row1/col1) steady -> one event, key_code = 0x5, key_valid high for 1 cycle; key_down = 1; no further events while held (macro off).
- Press key 5 with 1-sweep glitches every other sweep -> no event. Then hold steady -> event 0x5 within 3-4 sweeps (48-64 cycles + 3).
- Keys 2 and E held together -> single event 0xE. Release E, keeping 2 held -> event 0x2 after debounce. Release 2 -> key_down = 0, no event.
- key_ready = 0: press 3, release, press 7 -> key_valid holds 0x3, overflow pulses once for 7. key_ready = 1 -> 0x3 consumed, key_valid drops.
- Assert rst mid-sweep with key_valid = 1 -> next cycle key_valid = 0, col_n = 1110, key_down = 0. With the macro on: hold key 9 for 32+16 sweeps -> events at press, then at +32 and +40 sweeps.
